uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one byte-level UART transmit serializer between NUM_REQ requesters, such as the telemetry, debug and status message sources.
- Round-robin arbitration with per-requester valid/ready handshakes.
- Message locking: the owner keeps the link until it sends a byte marked last.
- Drives the serializer through a start/busy handshake and inserts a programmable idle gap between frames.
- Sits between the message sources and the serializer, which owns the tx pin and bit timing.

Parameters:
NUM_REQ, 4, number of requesters.
ID_W, 2, width of grant_id; must equal clog2(NUM_REQ).
GAP_CLKS, 28, idle clocks inserted after each frame completes (one bit time at clk_3125k); 0 means no gap.
START_TO, 4, clocks to wait for tx_busy to rise after tx_start before declaring an error.
LOCK_TO, 1024, clocks a locked owner may stall between bytes before the lock is released.

Ports:
clk_3125k  in  1  system clock, 3.125 MHz.
rst_n  in  1  reset; one clock, asynchronous, active-low.
req_valid  in  NUM_REQ  per-requester byte available.
req_data  in  8*NUM_REQ  byte of requester i on bits [8i+7:8i].
req_last  in  NUM_REQ  byte is the final byte of its message.
req_ready  out  NUM_REQ  one-hot acceptance pulse.
tx_start  out  1  one-cycle start pulse to the serializer.
tx_data  out  8  byte to the serializer; held stable until the next accept.
tx_busy  in  1  serializer is transmitting a frame.
grant_id  out  ID_W  current/last owner.
active  out  1  high whenever state is not IDLE.
tx_err  out  1  one-cycle pulse on start timeout.

Behaviour:
- Reset values (async, rst_n=0): state IDLE, req_ready=0, tx_start=0, tx_data=8'h00, grant_id=0, active=0, tx_err=0, rr pointer=0, lock=0, all counters 0.
- Reset mid-frame aborts sequencing immediately. The serializer is not aborted by this block.
- Arbitration order is pointer, pointer+1, ... mod NUM_REQ. The first requester with req_valid=1 wins.
- IDLE:
  - If any req_valid=1, register the winner into grant_id and go to SEND next cycle.
  - If none, stay in IDLE.
- SEND (exactly 1 cycle):
  - req_ready[grant_id]=1 (all other bits 0); this is the transfer.
  - Register tx_data <= byte of grant_id.
  - Register lock <= !req_last[grant_id].
  - Go to START.
- START (1 cycle): tx_start=1; go to WAIT_BUSY with the timeout counter cleared.
- Latency: req_valid seen in IDLE at cycle k gives req_ready at k+1 and tx_start at k+2.
- WAIT_BUSY:
  - If tx_busy=1, go to WAIT_DONE. tx_busy already high in the first WAIT_BUSY cycle is accepted.
  - Otherwise count. On the START_TO-th cycle without busy:
    - pulse tx_err;
    - force lock=0;
    - set pointer to grant_id+1 mod NUM_REQ;
    - go to IDLE.
- WAIT_DONE: stay while tx_busy=1. On tx_busy=0, go to GAP, or skip GAP if GAP_CLKS=0.
- GAP: count exactly GAP_CLKS cycles, then:
  - if lock=1, go to HOLD with the lock counter cleared;
  - else set pointer to grant_id+1 mod NUM_REQ and go to IDLE.
- HOLD (locked):
  - Only the owner is considered; other requesters are ignored.
  - If req_valid[grant_id]=1, go to SEND.
  - After LOCK_TO cycles without valid: lock=0, pointer advances past the owner, go to IDLE. No error is flagged.
- Requesters must hold req_valid, req_data and req_last stable until req_ready. Dropping valid early is illegal and not checked.
- Simultaneous events:
  - A new req_valid during WAIT_BUSY, WAIT_DONE or GAP is only sampled in IDLE or HOLD.
  - tx_busy falling and a new request in the same cycle: GAP still applies.
- Wrap-around: pointer NUM_REQ-1 advances to 0. The pointer changes only at message end or timeout.
- The tx_err timeout takes priority over a tx_busy that rises in the same cycle the count expires.

Test Plan:
- Single byte: req 2 valid, data 8'hA5, last=1 → req_ready=4'b0100 at k+1, tx_start at k+2, tx_data=8'hA5; bench busy for 280 clks then 28 gap clks → IDLE; pointer=3.
- All four valid with last=1 from reset → grant order 0,1,2,3, then 0 again; each tx_start separated by at least busy+28 clocks.
- Locked message: req 1 sends 3 bytes (last=0,0,1) while req 0 and req 3 are also valid → req 1 is served 3 times consecutively, then req 3, then req 0.
- Lock timeout: req 1 sends one byte with last=0 and then drops valid → after the gap, 1024 HOLD cycles, then req 2 is granted; tx_err stays 0.
- Start timeout: tx_busy held 0 → tx_err pulses exactly 4 cycles after tx_start, lock is cleared, the next requester is granted.
- Reset mid-WAIT_DONE: rst_n=0 → all outputs at reset values the same cycle; after release a pending req 0 is granted first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// uart_tx_arbiter: round-robin sharing of one UART byte serializer,
// with message locking, start timeout and an inter-frame idle gap.
module uart_tx_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int GAP_CLKS = 28,
  parameter int START_TO = 4,
  parameter int LOCK_TO  = 1024
) (
  input  logic                 clk_3125k,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 active,
  output logic                 tx_err
);

  localparam int C_A = (GAP_CLKS > START_TO) ? GAP_CLKS : START_TO;
  localparam int C_MAX = (LOCK_TO > C_A) ? LOCK_TO : C_A;
  localparam int CNT_W = $clog2(C_MAX + 1);
  localparam int GAP_M = (GAP_CLKS > 0) ? GAP_CLKS - 1 : 0;

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TO - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_M);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP,
    S_HOLD
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [ID_W-1:0]  r_grant, w_grant_nxt;
  logic [ID_W-1:0]  r_ptr, w_ptr_nxt;
  logic             r_lock, w_lock_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]       r_data, w_data_nxt;

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic                 w_found;
  logic [ID_W-1:0]      w_off;
  logic [ID_W:0]        w_sum;
  logic [ID_W-1:0]      w_win;
  logic [ID_W-1:0]      w_adv;
  logic [7:0]           w_byte;
  logic                 w_end;

  // Rotate valids so bit 0 is the pointer, then take the lowest set bit.
  always_comb begin
    w_dbl   = {req_valid, req_valid} >> r_ptr;
    w_rot   = w_dbl[NUM_REQ-1:0];
    w_found = |w_rot;
    w_off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = ID_W'(i);
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
      w_sum = w_sum - (ID_W+1)'(NUM_REQ);
    end
    w_win = w_sum[ID_W-1:0];
  end

  always_comb begin
    w_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant == ID_W'(i)) w_byte = req_data[8*i +: 8];
    end
  end

  assign w_adv = (r_grant == ID_W'(NUM_REQ - 1)) ?
                 '0 : r_grant + ID_W'(1);

  always_ff @(posedge clk_3125k or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_lock  <= 1'b0;
      r_cnt   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
      r_lock  <= w_lock_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_lock_nxt  = r_lock;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_end       = 1'b0;
    tx_err      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_win;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        w_data_nxt  = w_byte;
        w_lock_nxt  = !req_last[r_grant];
        w_state_nxt = S_START;
      end
      S_START: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT_BUSY;
      end
      // Timeout wins over a busy that rises on the expiring cycle.
      S_WAIT_BUSY: begin
        if (r_cnt == START_LAST) begin
          tx_err      = 1'b1;
          w_lock_nxt  = 1'b0;
          w_ptr_nxt   = w_adv;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (tx_busy) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_WAIT_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (GAP_CLKS == 0) begin
            w_end = 1'b1;
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) w_end = 1'b1;
        else w_cnt_nxt = r_cnt + CNT_W'(1);
      end
      S_HOLD: begin
        if (req_valid[r_grant]) begin
          w_state_nxt = S_SEND;
        end else if (r_cnt == LOCK_LAST) begin
          w_lock_nxt  = 1'b0;
          w_ptr_nxt   = w_adv;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_end) begin
      w_cnt_nxt = '0;
      if (r_lock) begin
        w_state_nxt = S_HOLD;
      end else begin
        w_ptr_nxt   = w_adv;
        w_state_nxt = S_IDLE;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (r_state == S_SEND) req_ready[r_grant] = 1'b1;
  end

  assign tx_start = (r_state == S_START);
  assign tx_data  = r_data;
  assign grant_id = r_grant;
  assign active   = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// tb_uart_tx_arbiter: directed scenarios for the shared UART transmit
// arbiter, with a small serializer model answering tx_start.
module tb_uart_tx_arbiter;

  logic        clk_3125k = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        tx_err;

  int tests = 0;
  int fails = 0;
  int busy_len = 10;

  uart_tx_arbiter #(
    .NUM_REQ(4), .ID_W(2), .GAP_CLKS(28),
    .START_TO(4), .LOCK_TO(1024)
  ) dut (
    .clk_3125k(clk_3125k),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .grant_id(grant_id),
    .active(active),
    .tx_err(tx_err)
  );

  always #5 clk_3125k = ~clk_3125k;

  // Serializer: busy rises mid-start-cycle and lasts busy_len clocks.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk_3125k);
      if (tx_start === 1'b1 && busy_len > 0) begin
        tx_busy = 1'b1;
        repeat (busy_len) @(negedge clk_3125k);
        tx_busy = 1'b0;
      end
    end
  end

  task automatic tick;
    @(posedge clk_3125k);
    #1;
  endtask

  task automatic wait_idle(input int lim, output int n);
    n = 0;
    while (active === 1'b1 && n < lim) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset;
    @(posedge clk_3125k);
    #1 rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [16:0] o;
    #2;
    o = {req_ready, tx_start, tx_data, grant_id, active, tx_err};
    tests++;
    if (o !== 17'h0) begin
      fails++;
      $display("FAIL reset_outs: got %h want %h", o, 17'h0);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tests++;
    if (active !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: active got %b want 0", active);
    end
  endtask

  task automatic test_single_byte;
    int n;
    busy_len  = 280;
    req_data  = 32'h00A5_0000;
    req_last  = 4'b0100;
    req_valid = 4'b0100;
    tick();
    tests++;
    if (req_ready !== 4'b0100 || grant_id !== 2'd2 || tx_start !== 1'b0) begin
      fails++;
      $display("FAIL single_send: ready %b gid %0d start %b want 0100 2 0",
               req_ready, grant_id, tx_start);
    end
    tick();
    req_valid = 4'b0000;
    tests++;
    if (tx_start !== 1'b1 || req_ready !== 4'b0000 || tx_data !== 8'hA5) begin
      fails++;
      $display("FAIL single_start: start %b ready %b data %h want 1 0000 a5",
               tx_start, req_ready, tx_data);
    end
    wait_idle(2000, n);
    tests++;
    if (n !== 309) begin
      fails++;
      $display("FAIL single_idle_lat: got %0d want 309", n);
    end
    tests++;
    if (tx_data !== 8'hA5) begin
      fails++;
      $display("FAIL single_hold_data: got %h want a5", tx_data);
    end
  endtask

  task automatic test_wrap;
    int n;
    busy_len  = 10;
    req_data  = 32'h3C00_00C0;
    req_last  = 4'b1001;
    req_valid = 4'b1001;
    tick();
    tests++;
    if (grant_id !== 2'd3 || req_ready !== 4'b1000) begin
      fails++;
      $display("FAIL wrap_first: gid %0d ready %b want 3 1000",
               grant_id, req_ready);
    end
    tick();
    req_valid = 4'b0001;
    tests++;
    if (tx_data !== 8'h3C) begin
      fails++;
      $display("FAIL wrap_data3: got %h want 3c", tx_data);
    end
    n = 0;
    while (req_ready === 4'b0000 && n < 200) begin
      tick();
      n++;
    end
    tests++;
    if (grant_id !== 2'd0 || req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL wrap_next: gid %0d ready %b want 0 0001",
               grant_id, req_ready);
    end
    tick();
    req_valid = 4'b0000;
    tests++;
    if (tx_data !== 8'hC0) begin
      fails++;
      $display("FAIL wrap_data0: got %h want c0", tx_data);
    end
    wait_idle(200, n);
  endtask

  task automatic test_round_robin;
    int g[5];
    int ts[5];
    int ng, ns, c;
    do_reset();
    busy_len  = 10;
    req_data  = 32'h4433_2211;
    req_last  = 4'b1111;
    req_valid = 4'b1111;
    ng = 0; ns = 0; c = 0;
    while (ns < 5 && c < 1000) begin
      tick();
      c++;
      if (req_ready !== 4'b0000 && ng < 5) begin
        g[ng] = int'(grant_id);
        tests++;
        if (req_ready !== (4'b0001 << grant_id)) begin
          fails++;
          $display("FAIL rr_onehot: ready %b gid %0d", req_ready, grant_id);
        end
        ng++;
      end
      if (tx_start === 1'b1) begin
        ts[ns] = c;
        ns++;
      end
    end
    req_valid = 4'b0000;
    tests++;
    if (ns !== 5) begin
      fails++;
      $display("FAIL rr_starts: got %0d want 5", ns);
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests++;
        if (g[i] !== i % 4) begin
          fails++;
          $display("FAIL rr_order[%0d]: got %0d want %0d", i, g[i], i % 4);
        end
      end
      for (int i = 1; i < 5; i++) begin
        tests++;
        if (ts[i] - ts[i-1] !== 41) begin
          fails++;
          $display("FAIL rr_spacing[%0d]: got %0d want 41",
                   i, ts[i] - ts[i-1]);
        end
      end
    end
    wait_idle(200, c);
  endtask

  task automatic test_lock;
    int g[5];
    logic [7:0] d[5];
    int exp_g[5];
    logic [7:0] exp_d[5];
    int ng, ns, c, pend, b1;
    exp_g = '{1, 1, 1, 3, 0};
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h3C, 8'hC0};
    req_data  = 32'h3C00_11C0;
    req_last  = 4'b1001;
    req_valid = 4'b1011;
    ng = 0; ns = 0; c = 0; pend = -1; b1 = 0;
    while (ns < 5 && c < 3000) begin
      tick();
      c++;
      if (pend == 1) begin
        b1++;
        if (b1 == 1) req_data[15:8] = 8'h22;
        if (b1 == 2) begin
          req_data[15:8] = 8'h33;
          req_last[1] = 1'b1;
        end
        if (b1 == 3) req_valid[1] = 1'b0;
      end else if (pend == 0) begin
        req_valid[0] = 1'b0;
      end else if (pend == 3) begin
        req_valid[3] = 1'b0;
      end
      pend = -1;
      if (req_ready !== 4'b0000 && ng < 5) begin
        g[ng] = int'(grant_id);
        pend = int'(grant_id);
        ng++;
      end
      if (tx_start === 1'b1) begin
        d[ns] = tx_data;
        ns++;
      end
    end
    tests++;
    if (ns !== 5 || ng !== 5) begin
      fails++;
      $display("FAIL lock_count: starts %0d grants %0d want 5 5", ns, ng);
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests++;
        if (g[i] !== exp_g[i] || d[i] !== exp_d[i]) begin
          fails++;
          $display("FAIL lock_seq[%0d]: gid %0d data %h want %0d %h",
                   i, g[i], d[i], exp_g[i], exp_d[i]);
        end
      end
    end
    req_valid = 4'b0000;
    wait_idle(200, c);
  endtask

  task automatic test_lock_timeout;
    int g[2];
    int rc[2];
    int ng, c, s0, errs, pend;
    req_data  = 32'h00B2_5A00;
    req_last  = 4'b0100;
    req_valid = 4'b0110;
    ng = 0; c = 0; s0 = -1; errs = 0; pend = -1;
    while (ng < 2 && c < 3000) begin
      tick();
      c++;
      if (pend >= 0) req_valid = req_valid & ~(4'b0001 << pend);
      pend = -1;
      if (req_ready !== 4'b0000) begin
        g[ng] = int'(grant_id);
        rc[ng] = c;
        pend = int'(grant_id);
        ng++;
      end
      if (tx_start === 1'b1 && s0 < 0) s0 = c;
      if (tx_err !== 1'b0) errs++;
    end
    tests++;
    if (ng !== 2) begin
      fails++;
      $display("FAIL lockto_grants: got %0d want 2", ng);
    end else begin
      tests++;
      if (g[0] !== 1 || g[1] !== 2) begin
        fails++;
        $display("FAIL lockto_order: got %0d %0d want 1 2", g[0], g[1]);
      end
      tests++;
      if (rc[1] - s0 !== 1064) begin
        fails++;
        $display("FAIL lockto_lat: got %0d want 1064", rc[1] - s0);
      end
    end
    tick();
    req_valid = 4'b0000;
    wait_idle(200, c);
    tests++;
    if (errs !== 0) begin
      fails++;
      $display("FAIL lockto_err: got %0d pulses want 0", errs);
    end
  endtask

  task automatic test_start_timeout;
    int g[2];
    int rc[2];
    int sc[2];
    int ec[2];
    int ng, ns, ne, pend;
    busy_len  = 0;
    req_data  = 32'h7700_0088;
    req_last  = 4'b0001;
    req_valid = 4'b1001;
    ng = 0; ns = 0; ne = 0; pend = -1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (pend >= 0) req_valid = req_valid & ~(4'b0001 << pend);
      pend = -1;
      if (req_ready !== 4'b0000 && ng < 2) begin
        g[ng] = int'(grant_id);
        rc[ng] = c;
        pend = int'(grant_id);
        ng++;
      end
      if (tx_start === 1'b1 && ns < 2) begin
        sc[ns] = c;
        ns++;
      end
      if (tx_err === 1'b1) begin
        if (ne < 2) ec[ne] = c;
        ne++;
      end
    end
    tests++;
    if (ng !== 2 || ns !== 2 || ne !== 2) begin
      fails++;
      $display("FAIL sto_counts: grants %0d starts %0d errs %0d want 2 2 2",
               ng, ns, ne);
    end else begin
      tests++;
      if (g[0] !== 3 || g[1] !== 0) begin
        fails++;
        $display("FAIL sto_order: got %0d %0d want 3 0", g[0], g[1]);
      end
      tests++;
      if (ec[0] - sc[0] !== 4 || ec[1] - sc[1] !== 4) begin
        fails++;
        $display("FAIL sto_err_lat: got %0d %0d want 4 4",
                 ec[0] - sc[0], ec[1] - sc[1]);
      end
      tests++;
      if (rc[1] - ec[0] !== 2) begin
        fails++;
        $display("FAIL sto_regrant: got %0d want 2", rc[1] - ec[0]);
      end
    end
    tests++;
    if (active !== 1'b0) begin
      fails++;
      $display("FAIL sto_idle: active got %b want 0", active);
    end
    busy_len = 10;
  endtask

  task automatic test_reset_mid;
    logic [16:0] o;
    int n;
    busy_len  = 20;
    req_data  = 32'h0000_9900;
    req_last  = 4'b0010;
    req_valid = 4'b0010;
    n = 0;
    while (tx_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    req_valid = 4'b0000;
    repeat (5) tick();
    tests++;
    if (active !== 1'b1 || tx_busy !== 1'b1) begin
      fails++;
      $display("FAIL rmid_pre: active %b busy %b want 1 1", active, tx_busy);
    end
    req_data  = 32'h00D2_00D0;
    req_last  = 4'b0101;
    req_valid = 4'b0101;
    #1 rst_n = 1'b0;
    #1;
    o = {req_ready, tx_start, tx_data, grant_id, active, tx_err};
    tests++;
    if (o !== 17'h0) begin
      fails++;
      $display("FAIL rmid_outs: got %h want %h", o, 17'h0);
    end
    repeat (25) tick();
    rst_n = 1'b1;
    n = 0;
    while (req_ready === 4'b0000 && n < 10) begin
      tick();
      n++;
    end
    tests++;
    if (grant_id !== 2'd0 || req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL rmid_grant: gid %0d ready %b want 0 0001",
               grant_id, req_ready);
    end
    tick();
    req_valid = 4'b0000;
    wait_idle(200, n);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_data  = 32'h0;
    req_last  = 4'b0000;
    test_reset();
    test_single_byte();
    test_wrap();
    test_round_robin();
    test_lock();
    test_lock_timeout();
    test_start_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
